// File: rtl/yuv420_unpack.sv
// Unpacks a packed 32-bit raw / YUV444 / YUV420 word stream into one Y/U/V pixel per cycle,
// regenerating row and frame framing from the sampled geometry; outputs are registered.
module yuv420_unpack #(
  parameter int MAX_COLS    = 1288,
  parameter int MAX_ROWS    = 1024,
  parameter int DTYPE_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [15:0]            image_type,
  input  logic                   enable,
  input  logic [15:0]            num_cols,
  input  logic [15:0]            num_rows,
  input  logic                   dvi,
  output logic                   rdyo,
  input  logic [DTYPE_WIDTH-1:0] dtypei,
  input  logic [31:0]            datai,
  output logic                   dvo,
  output logic [DTYPE_WIDTH-1:0] dtypeo,
  output logic [15:0]            meta_datao,
  output logic [7:0]             yo,
  output logic [7:0]             uo,
  output logic [7:0]             vo,
  output logic                   uv_new,
  output logic                   frame_err
);

  localparam int CW = $clog2(MAX_COLS);
  localparam int RW = $clog2(MAX_ROWS);

  localparam logic [DTYPE_WIDTH-1:0] DT_FRAME_START  = DTYPE_WIDTH'(1);
  localparam logic [DTYPE_WIDTH-1:0] DT_FRAME_END    = DTYPE_WIDTH'(2);
  localparam logic [DTYPE_WIDTH-1:0] DT_ROW_START    = DTYPE_WIDTH'(3);
  localparam logic [DTYPE_WIDTH-1:0] DT_ROW_END      = DTYPE_WIDTH'(4);
  localparam logic [DTYPE_WIDTH-1:0] DT_PIXEL        = DTYPE_WIDTH'(5);
  localparam logic [DTYPE_WIDTH-1:0] DT_HEADER_START = DTYPE_WIDTH'(6);
  localparam logic [DTYPE_WIDTH-1:0] DT_HEADER       = DTYPE_WIDTH'(7);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_HDR2, S_ROW_S, S_PIX, S_ROW_E, S_WAIT_END, S_FE_OUT
  } state_t;

  state_t          state_q;
  logic [7:0]      buf_q [8];
  logic [2:0]      rd_ptr_q, rd_ptr_d, wr_base;
  logic [3:0]      fill_q, fill_d, need, consumed;
  logic [CW-1:0]   col_q, last_col_q;
  logic [RW-1:0]   row_q, last_row_q;
  logic            raw_q, yuv420_q;
  logic [15:0]     hi_q;
  logic            in_frame, take, accept, fs_acc, fe_acc, append, flush;

  always_comb begin
    in_frame = (state_q == S_ROW_S) || (state_q == S_PIX) || (state_q == S_ROW_E);
    if (raw_q)                       need = 4'd1;
    else if (!yuv420_q)              need = 4'd3;
    else if (row_q[0] && col_q[0])   need = 4'd3;
    else                             need = 4'd1;
    take     = (state_q == S_PIX) && (fill_q >= need);
    consumed = take ? need : 4'd0;
    case (state_q)
      S_IDLE, S_HDR, S_WAIT_END: rdyo = 1'b1;
      S_ROW_S, S_PIX, S_ROW_E:   rdyo = ((fill_q - consumed) <= 4'd4);
      default:                   rdyo = 1'b0;
    endcase
    accept   = dvi && rdyo;
    fs_acc   = accept && (dtypei == DT_FRAME_START);
    fe_acc   = accept && (dtypei == DT_FRAME_END);
    append   = accept && (dtypei == DT_PIXEL) && in_frame;
    flush    = fs_acc || fe_acc;
    wr_base  = rd_ptr_q + fill_q[2:0];
    fill_d   = flush ? 4'd0 : (fill_q - consumed + (append ? 4'd4 : 4'd0));
    rd_ptr_d = flush ? 3'd0 : (rd_ptr_q + consumed[2:0]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      fill_q     <= 4'd0;
      rd_ptr_q   <= 3'd0;
      for (int k = 0; k < 8; k++) buf_q[k] <= 8'h00;
      col_q      <= '0;
      row_q      <= '0;
      last_col_q <= '0;
      last_row_q <= '0;
      raw_q      <= 1'b0;
      yuv420_q   <= 1'b0;
      hi_q       <= 16'h0;
      dvo        <= 1'b0;
      dtypeo     <= '0;
      meta_datao <= 16'h0;
      yo         <= 8'h00;
      uo         <= 8'h80;
      vo         <= 8'h80;
      uv_new     <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      fill_q   <= fill_d;
      rd_ptr_q <= rd_ptr_d;
      if (append) begin
        for (int k = 0; k < 4; k++) buf_q[wr_base + 3'(k)] <= datai[8*k +: 8];
      end
      dvo    <= 1'b0;
      uv_new <= 1'b0;
      if (fs_acc) begin
        // A start outside IDLE/HDR abandons the frame in progress.
        dvo        <= 1'b1;
        dtypeo     <= DT_FRAME_START;
        frame_err  <= !((state_q == S_IDLE) || (state_q == S_HDR));
        raw_q      <= (image_type == 16'h0);
        yuv420_q   <= enable;
        last_col_q <= CW'(num_cols - 16'd1);
        last_row_q <= RW'(num_rows - 16'd1);
        col_q      <= '0;
        row_q      <= '0;
        uo         <= 8'h80;
        vo         <= 8'h80;
        state_q    <= S_ROW_S;
      end else begin
        case (state_q)
          S_IDLE, S_HDR: begin
            if (accept && dtypei == DT_HEADER_START) begin
              dvo     <= 1'b1;
              dtypeo  <= DT_HEADER_START;
              state_q <= S_HDR;
            end else if (accept && dtypei == DT_HEADER && state_q == S_HDR) begin
              dvo        <= 1'b1;
              dtypeo     <= DT_HEADER;
              meta_datao <= datai[15:0];
              hi_q       <= datai[31:16];
              state_q    <= S_HDR2;
            end
          end
          S_HDR2: begin
            dvo        <= 1'b1;
            dtypeo     <= DT_HEADER;
            meta_datao <= hi_q;
            state_q    <= S_HDR;
          end
          S_ROW_S: begin
            dvo <= 1'b1;
            if (fe_acc) begin
              frame_err <= 1'b1;
              dtypeo    <= DT_FRAME_END;
              state_q   <= S_IDLE;
            end else begin
              dtypeo  <= DT_ROW_START;
              state_q <= S_PIX;
            end
          end
          S_PIX: begin
            if (fe_acc) begin
              frame_err <= 1'b1;
              dvo       <= 1'b1;
              dtypeo    <= DT_ROW_END;
              state_q   <= S_FE_OUT;
            end else if (take) begin
              dvo    <= 1'b1;
              dtypeo <= DT_PIXEL;
              yo     <= buf_q[rd_ptr_q];
              if (need == 4'd3) begin
                uo     <= buf_q[rd_ptr_q + 3'd1];
                vo     <= buf_q[rd_ptr_q + 3'd2];
                uv_new <= 1'b1;
              end
              if (col_q == last_col_q) begin
                col_q   <= '0;
                state_q <= S_ROW_E;
              end else begin
                col_q <= col_q + 1'b1;
              end
            end
          end
          S_ROW_E: begin
            dvo    <= 1'b1;
            dtypeo <= DT_ROW_END;
            if (fe_acc) begin
              frame_err <= 1'b1;
              state_q   <= S_FE_OUT;
            end else if (row_q == last_row_q) begin
              state_q <= S_WAIT_END;
            end else begin
              row_q   <= row_q + 1'b1;
              state_q <= S_ROW_S;
            end
          end
          S_WAIT_END: begin
            if (fe_acc) begin
              dvo     <= 1'b1;
              dtypeo  <= DT_FRAME_END;
              state_q <= S_IDLE;
            end
          end
          S_FE_OUT: begin
            dvo     <= 1'b1;
            dtypeo  <= DT_FRAME_END;
            state_q <= S_IDLE;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_yuv420_unpack.sv
// Directed bench for yuv420_unpack: drives packed words and compares the emitted stream.
module tb_yuv420_unpack;

  localparam logic [3:0] DT_FS = 4'd1, DT_FE = 4'd2, DT_RS = 4'd3, DT_RE = 4'd4;
  localparam logic [3:0] DT_PX = 4'd5, DT_HS = 4'd6, DT_HD = 4'd7;

  logic        clk, reset, enable, dvi, rdyo, dvo, uv_new, frame_err;
  logic [15:0] image_type, num_cols, num_rows, meta_datao;
  logic [3:0]  dtypei, dtypeo;
  logic [31:0] datai;
  logic [7:0]  yo, uo, vo;

  yuv420_unpack #(.MAX_COLS(1288), .MAX_ROWS(1024), .DTYPE_WIDTH(4)) dut (
    .clk(clk), .reset(reset), .image_type(image_type), .enable(enable),
    .num_cols(num_cols), .num_rows(num_rows), .dvi(dvi), .rdyo(rdyo),
    .dtypei(dtypei), .datai(datai), .dvo(dvo), .dtypeo(dtypeo),
    .meta_datao(meta_datao), .yo(yo), .uo(uo), .vo(vo), .uv_new(uv_new),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  dt;
    logic [15:0] meta;
    logic [7:0]  y, u, v;
    logic        uvn;
    int          cyc;
  } rec_t;

  rec_t got_q[$];
  rec_t exp_q[$];
  int   n_chk = 0, n_pass = 0, cyc = 0;
  logic watch_rdyo = 1'b0, saw_low = 1'b0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (watch_rdyo && !rdyo) saw_low <= 1'b1;
    if (dvo) begin
      rec_t r;
      r.dt = dtypeo; r.meta = meta_datao; r.y = yo; r.u = uo; r.v = vo;
      r.uvn = uv_new; r.cyc = cyc;
      got_q.push_back(r);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic ex(input logic [3:0] dt, input logic [7:0] y = 8'h00,
                    input logic [7:0] u = 8'h80, input logic [7:0] v = 8'h80,
                    input logic uvn = 1'b0, input logic [15:0] meta = 16'h0);
    rec_t r;
    r.dt = dt; r.y = y; r.u = u; r.v = v; r.uvn = uvn; r.meta = meta; r.cyc = 0;
    exp_q.push_back(r);
  endtask

  task automatic ex_raw_row(input logic [7:0] base);
    ex(DT_RS);
    for (int k = 0; k < 4; k++) ex(DT_PX, 8'(base + 8'(k)));
    ex(DT_RE);
  endtask

  // Called at posedge+1; holds dvi until a rising edge sees rdyo high.
  task automatic send(input logic [3:0] dt, input logic [31:0] d);
    logic acc;
    int   n;
    dtypei = dt; datai = d; dvi = 1'b1; n = 0;
    forever begin
      @(negedge clk);
      acc = rdyo;
      @(posedge clk);
      #1;
      if (acc) break;
      n++;
      if (n > 200) begin
        chk("send_timeout", 32'd0, 32'd1);
        break;
      end
    end
    dvi = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cmp_stream(input string tag);
    chk({tag, ".len"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      chk($sformatf("%s[%0d].dt", tag, i), got_q[i].dt, exp_q[i].dt);
      if (exp_q[i].dt == DT_PX) begin
        chk($sformatf("%s[%0d].y", tag, i), got_q[i].y, exp_q[i].y);
        chk($sformatf("%s[%0d].u", tag, i), got_q[i].u, exp_q[i].u);
        chk($sformatf("%s[%0d].v", tag, i), got_q[i].v, exp_q[i].v);
        chk($sformatf("%s[%0d].uvn", tag, i), got_q[i].uvn, exp_q[i].uvn);
      end
      if (exp_q[i].dt == DT_HD)
        chk($sformatf("%s[%0d].meta", tag, i), got_q[i].meta, exp_q[i].meta);
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic cfg(input logic [15:0] it, input logic en, input logic [15:0] c, input logic [15:0] r);
    image_type = it; enable = en; num_cols = c; num_rows = r;
  endtask

  initial begin
    clk = 1'b0; reset = 1'b1; dvi = 1'b0; dtypei = '0; datai = '0;
    cfg(16'h0, 1'b0, 16'd4, 16'd2);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst.dvo", dvo, 1'b0);
    chk("rst.dtypeo", dtypeo, 4'd0);
    chk("rst.meta", meta_datao, 16'h0);
    chk("rst.yo", yo, 8'h00);
    chk("rst.uo", uo, 8'h80);
    chk("rst.vo", vo, 8'h80);
    chk("rst.uv_new", uv_new, 1'b0);
    chk("rst.frame_err", frame_err, 1'b0);
    chk("rst.rdyo", rdyo, 1'b1);
    @(posedge clk); #1;
    got_q.delete();

    // Raw 4x2
    cfg(16'h0, 1'b0, 16'd4, 16'd2);
    send(DT_FS, 32'h0);
    send(DT_PX, 32'h03020100);
    send(DT_PX, 32'h07060504);
    idle(20);
    send(DT_FE, 32'h0);
    idle(5);
    ex(DT_FS); ex_raw_row(8'h00); ex_raw_row(8'h04); ex(DT_FE);
    cmp_stream("raw");
    chk("raw.frame_err", frame_err, 1'b0);

    // 4:2:0 4x2 with one padding word
    cfg(16'h1, 1'b1, 16'd4, 16'd2);
    send(DT_FS, 32'h0);
    send(DT_PX, 32'h13121110);
    send(DT_PX, 32'hB0A02120);
    send(DT_PX, 32'hB1A12322);
    send(DT_PX, 32'hDEADBEEF);
    idle(20);
    send(DT_FE, 32'h0);
    idle(5);
    ex(DT_FS); ex(DT_RS);
    ex(DT_PX, 8'h10); ex(DT_PX, 8'h11); ex(DT_PX, 8'h12); ex(DT_PX, 8'h13);
    ex(DT_RE); ex(DT_RS);
    ex(DT_PX, 8'h20);
    ex(DT_PX, 8'h21, 8'hA0, 8'hB0, 1'b1);
    ex(DT_PX, 8'h22, 8'hA0, 8'hB0, 1'b0);
    ex(DT_PX, 8'h23, 8'hA1, 8'hB1, 1'b1);
    ex(DT_RE); ex(DT_FE);
    cmp_stream("yuv420");
    chk("yuv420.frame_err", frame_err, 1'b0);

    // 4:4:4 2x2, back-to-back words must hit backpressure
    cfg(16'h1, 1'b0, 16'd2, 16'd2);
    send(DT_FS, 32'h0);
    saw_low = 1'b0; watch_rdyo = 1'b1;
    send(DT_PX, 32'h04030201);
    send(DT_PX, 32'h08070605);
    send(DT_PX, 32'h0C0B0A09);
    idle(20);
    watch_rdyo = 1'b0;
    chk("yuv444.rdyo_low", saw_low, 1'b1);
    send(DT_FE, 32'h0);
    idle(5);
    ex(DT_FS); ex(DT_RS);
    ex(DT_PX, 8'h01, 8'h02, 8'h03, 1'b1);
    ex(DT_PX, 8'h04, 8'h05, 8'h06, 1'b1);
    ex(DT_RE); ex(DT_RS);
    ex(DT_PX, 8'h07, 8'h08, 8'h09, 1'b1);
    ex(DT_PX, 8'h0A, 8'h0B, 8'h0C, 1'b1);
    ex(DT_RE); ex(DT_FE);
    cmp_stream("yuv444");

    // Header words split into halfwords on consecutive cycles
    send(DT_HS, 32'h0);
    send(DT_HD, 32'h00020001);
    send(DT_HD, 32'h00040003);
    idle(5);
    if (got_q.size() >= 5)
      for (int i = 1; i < 5; i++)
        chk($sformatf("hdr.consec%0d", i), 32'(got_q[i].cyc - got_q[i-1].cyc), 32'd1);
    ex(DT_HS);
    ex(DT_HD, 8'h00, 8'h80, 8'h80, 1'b0, 16'h0001);
    ex(DT_HD, 8'h00, 8'h80, 8'h80, 1'b0, 16'h0002);
    ex(DT_HD, 8'h00, 8'h80, 8'h80, 1'b0, 16'h0003);
    ex(DT_HD, 8'h00, 8'h80, 8'h80, 1'b0, 16'h0004);
    cmp_stream("hdr");

    // Truncated raw frame: row 1 is open when FRAME_END arrives
    cfg(16'h0, 1'b0, 16'd4, 16'd2);
    send(DT_FS, 32'h0);
    send(DT_PX, 32'h03020100);
    idle(12);
    send(DT_FE, 32'h0);
    idle(5);
    ex(DT_FS); ex_raw_row(8'h00); ex(DT_RS); ex(DT_RE); ex(DT_FE);
    cmp_stream("trunc");
    chk("trunc.frame_err", frame_err, 1'b1);

    // New frame clears frame_err; reset mid-row in PIX
    cfg(16'h1, 1'b1, 16'd4, 16'd2);
    send(DT_FS, 32'h0);
    chk("fs.clears_err", frame_err, 1'b0);
    send(DT_PX, 32'h13121110);
    send(DT_PX, 32'hB0A02120);
    idle(12);
    chk("pre_rst.uo", uo, 8'hA0);
    chk("pre_rst.vo", vo, 8'hB0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rst.dvo", dvo, 1'b0);
    chk("mid_rst.rdyo", rdyo, 1'b1);
    chk("mid_rst.uo", uo, 8'h80);
    chk("mid_rst.vo", vo, 8'h80);
    @(posedge clk); #1;
    got_q.delete();
    exp_q.delete();

    cfg(16'h0, 1'b0, 16'd4, 16'd2);
    send(DT_FS, 32'h0);
    send(DT_PX, 32'hA3A2A1A0);
    send(DT_PX, 32'hB3B2B1B0);
    idle(20);
    send(DT_FE, 32'h0);
    idle(5);
    ex(DT_FS); ex_raw_row(8'hA0); ex_raw_row(8'hB0); ex(DT_FE);
    cmp_stream("post_rst");
    chk("post_rst.frame_err", frame_err, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/yuv420_unpack.md
Name: yuv420_unpack

Overview:
- Receive-side inverse of the yuv420 packer. Consumes the packed 32-bit pixel-word stream (raw 8b, YUV 4:4:4 24b, or YUV 4:2:0 interleaved) and regenerates a one-pixel-per-cycle Y/U/V stream with dtype framing.
- Sits after the packed-stream transport (FIFO/host loopback), ahead of colour conversion or a verification scoreboard.

Parameters:
- MAX_COLS, 1288, upper bound on num_cols; sizes the column counter.
- MAX_ROWS, 1024, upper bound on num_rows; sizes the row counter.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- image_type  in  16  0 = raw 8b/pixel; non-zero = YUV
- enable  in  1  YUV only: 1 = 4:2:0 packing, 0 = 4:4:4 (3 bytes/pixel)
- num_cols  in  16  pixels per row; even, 2..MAX_COLS
- num_rows  in  16  rows per frame; even, 2..MAX_ROWS
- dvi  in  1  input word valid
- rdyo  out  1  input accepted when dvi && rdyo
- dtypei  in  DTYPE_WIDTH  input dtype
- datai  in  32  packed word; first stream byte in datai[7:0]
- dvo  out  1  output valid (no downstream stall)
- dtypeo  out  DTYPE_WIDTH  output dtype
- meta_datao  out  16  header halfword
- yo, uo, vo  out  8 each  pixel components (raw byte on yo)
- uv_new  out  1  uo/vo freshly decoded this pixel
- frame_err  out  1  sticky until next FRAME_START: truncated frame

Behaviour:
- Reset: dvo=0, dtypeo=0, meta_datao=0, yo=0, uo=vo=8'h80, uv_new=0, frame_err=0, rdyo=1, byte buffer empty, state IDLE. Reset mid-frame discards everything.
- Byte buffer: 8 bytes, fill count 0..8. An accepted pixel word appends 4 bytes in the order [7:0], [15:8], [23:16], [31:24].
  - Same-cycle consume and append: fill_next = fill - consumed + 4.
  - rdyo = 1 in IDLE, HDR and WAIT_END.
  - rdyo = (fill - consumed_this_cycle <= 4) in ROW_S, PIX and ROW_E.
- States:
  - IDLE:
    - Accept HEADER_START: emit it, go to HDR.
    - Accept FRAME_START: emit it, clear buffer, counters, uo/vo (to 80h) and frame_err; go to ROW_S.
    - Other dtypes: dropped.
  - HDR:
    - Each accepted HEADER word emits two cycles: meta_datao=datai[15:0] with dtypeo=HEADER, then datai[31:16]. rdyo=0 during the second cycle.
    - FRAME_START handled as in IDLE.
  - ROW_S: emit ROW_START one cycle, go to PIX.
  - PIX:
    - Emit one PIXEL per cycle when the buffer holds the bytes needed, else dvo=0.
    - Bytes per pixel:
      - raw: 1 byte (yo).
      - 4:4:4: 3 bytes (y, u, v).
      - 4:2:0: 3 bytes (y, u, v) when row odd and col odd; otherwise 1 byte (y).
    - Row and col indices are 0-based.
    - On 3-byte 4:2:0 pixels: uo/vo update and uv_new=1. Otherwise uo/vo hold and uv_new=0. In 4:4:4, uv_new=1 on every pixel.
    - After column num_cols-1: go to ROW_E.
  - ROW_E:
    - Emit ROW_END one cycle.
    - If the row was num_rows-1, go to WAIT_END; else increment the row and go to ROW_S.
  - WAIT_END:
    - Accepted pixel words are padding: discard them.
    - Input FRAME_END: flush buffer, emit FRAME_END, go to IDLE.
- Input ROW_START/ROW_END dtypes are ignored in every state. Rows are regenerated from num_cols/num_rows, because packed words straddle row boundaries.
- Input FRAME_END in ROW_S, PIX or ROW_E (truncated frame):
  - Set frame_err, flush the buffer.
  - If PIX or ROW_E: emit ROW_END first (unless already emitting it).
  - Then emit FRAME_END and go to IDLE.
- Input FRAME_START outside IDLE/HDR: treat as a new frame. Set frame_err, restart the frame.
- Latency: a word accepted at cycle N can produce its first pixel at N+1. Outputs are registered.
- image_type, enable, num_cols and num_rows are sampled at FRAME_START and held for the frame.
- Counters are sized for MAX_COLS/MAX_ROWS. Buffer indexing is mod 8. A 3-byte pixel waits until fill >= 3 and never splits across cycles.

Test Plan:
- Raw, 4x2, words 03020100h, 07060504h, FRAME_END -> FS, RS, yo 00..03, RE, RS, yo 04..07, RE, FE; frame_err=0.
- 4:2:0, 4x2, byte stream 10 11 12 13 | 20 21 A0 B0 22 23 A1 B1 plus padding to 3 words -> row0 Y 10..13 with uo/vo=80h; row1 Y 20,21(uo=A0,vo=B0,uv_new=1),22,23(A1,B1); padding discarded.
- 4:4:4 (enable=0), 2x2, 12 bytes in 3 words -> 4 pixels with correct y/u/v and uv_new=1 each; rdyo deasserts while fill > 4.
- HEADER_START plus 2 HEADER words 0002_0001h, 0004_0003h -> meta_datao 0001, 0002, 0003, 0004 on consecutive dvo cycles.
- Raw 4x2 with FRAME_END after first word -> row0 pixels 00..03, RE, FE; frame_err=1; next FRAME_START clears frame_err.
- Reset asserted mid-row in PIX -> next cycle dvo=0, rdyo=1, uo=80h; a subsequent frame decodes correctly.
